// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one req/ack memory between fetch and data ports; data has priority,
// with a bounded streak of data grants so a pending fetch cannot starve.
module mem_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DC_STREAK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic [DATA_W-1:0] ic_rdata,
  output logic              ic_ready,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [DATA_W-1:0] dc_wdata,
  output logic [DATA_W-1:0] dc_rdata,
  output logic              dc_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);
  typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;
  localparam logic [3:0] MAX = 4'(MAX_DC_STREAK);
  state_t state_q, state_d;
  logic [3:0] streak_q, streak_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic ic_ready_q, ic_ready_d, dc_ready_q, dc_ready_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d;
  logic grant_dc;
  // data wins unless a fetch is waiting and the data streak is exhausted
  assign grant_dc = dc_req && !(ic_req && streak_q >= MAX);
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ic_rdata_d  = ic_rdata_q;
    dc_rdata_d  = dc_rdata_q;
    ic_ready_d  = 1'b0;
    dc_ready_d  = 1'b0;
    case (state_q)
      IDLE: if (ic_req || dc_req) begin
        state_d     = grant_dc ? BUSY_D : BUSY_I;
        mem_req_d   = 1'b1;
        mem_we_d    = grant_dc && dc_we;
        mem_addr_d  = grant_dc ? dc_addr : ic_addr;
        mem_wdata_d = grant_dc ? dc_wdata : mem_wdata_q;
        streak_d    = (grant_dc && ic_req) ? (streak_q >= MAX ? MAX : streak_q + 4'd1) : 4'd0;
      end
      BUSY_I, BUSY_D: if (mem_ack) begin
        state_d    = state_q == BUSY_I ? RESP_I : RESP_D;
        mem_req_d  = 1'b0;
        mem_we_d   = 1'b0;
        ic_ready_d = state_q == BUSY_I;
        dc_ready_d = state_q == BUSY_D;
        ic_rdata_d = state_q == BUSY_I ? mem_rdata : ic_rdata_q;
        dc_rdata_d = (state_q == BUSY_D && !mem_we_q) ? mem_rdata : dc_rdata_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ic_rdata_q  <= '0;
      dc_rdata_q  <= '0;
      ic_ready_q  <= 1'b0;
      dc_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ic_rdata_q  <= ic_rdata_d;
      dc_rdata_q  <= dc_rdata_d;
      ic_ready_q  <= ic_ready_d;
      dc_ready_q  <= dc_ready_d;
    end
  end
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign ic_rdata  = ic_rdata_q;
  assign dc_rdata  = dc_rdata_q;
  assign ic_ready  = ic_ready_q;
  assign dc_ready  = dc_ready_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed table, multi-cycle corner sequences and random traffic against a
// transaction-level model of the arbiter with a latency-programmable memory responder.
module tb_mem_arbiter;
  localparam int MAXS = 2;
  logic clk = 1'b0, reset = 1'b1;
  logic ic_req = 1'b0, dc_req = 1'b0, dc_we = 1'b0, mem_ack = 1'b0;
  logic [31:0] ic_addr = '0, dc_addr = '0, dc_wdata = '0, mem_rdata = '0;
  logic [31:0] ic_rdata, dc_rdata, mem_addr, mem_wdata;
  logic ic_ready, dc_ready, mem_req, mem_we;
  int checks = 0, errors = 0;
  int lat = 1, cnt = 0;
  bit spur = 1'b0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] cur_ic = '0, cur_dc = '0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DC_STREAK(MAXS)) dut (
    .clk(clk), .reset(reset),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_rdata(ic_rdata), .ic_ready(ic_ready),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wdata(dc_wdata),
    .dc_rdata(dc_rdata), .dc_ready(dc_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // memory: acks in the lat-th cycle of mem_req; rdata is garbage whenever not acking a load
  initial forever begin
    @(posedge clk);
    #2;
    if (reset) begin
      mem_ack = 1'b0; cnt = 0; mem_rdata = $urandom;
    end else if (spur && !mem_req) begin
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    end else if (mem_req && cnt < lat) begin
      cnt++;
      mem_ack = (cnt == lat);
      mem_rdata = $urandom;
      if (cnt == lat) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : ~mem_addr;
      end
    end else begin
      mem_ack = 1'b0;
      if (!mem_req) cnt = 0;
      mem_rdata = $urandom;
    end
  end

  always @(negedge clk) if (!reset) begin
    chkb("ready_exclusive", ic_ready && dc_ready, 1'b0);
    chkb("req_during_resp", mem_req && (ic_ready || dc_ready), 1'b0);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic i, input logic [31:0] ia, input logic d, input logic w,
                       input logic [31:0] da, input logic [31:0] wd);
    ic_req = i; ic_addr = ia; dc_req = d; dc_we = w; dc_addr = da; dc_wdata = wd;
  endtask

  // called at posedge+1 of an IDLE cycle (n = 0) with requests already driven
  task automatic run_txn(input string tag, input int l, input logic exp_d, input logic [31:0] exp_addr,
                         input logic exp_we, input logic [31:0] exp_wd, input logic [31:0] exp_ic,
                         input logic [31:0] exp_dc, input bit scr);
    int req_first, req_cnt, rdy;
    bit bad_hold;
    logic got_d;
    req_first = -1; req_cnt = 0; rdy = -1; bad_hold = 1'b0; got_d = 1'b0;
    lat = l;
    for (int n = 0; n < 60 && rdy < 0; n++) begin
      @(negedge clk);
      if (mem_req) begin
        if (req_first < 0) begin
          req_first = n;
          chk({tag, "_mem_addr"}, mem_addr, exp_addr);
          chkb({tag, "_mem_we"}, mem_we, exp_we);
          if (exp_we) chk({tag, "_mem_wdata"}, mem_wdata, exp_wd);
        end else if (mem_addr !== exp_addr || mem_we !== exp_we || (exp_we && mem_wdata !== exp_wd))
          bad_hold = 1'b1;
        req_cnt++;
        if (scr) begin
          ic_addr = $urandom; dc_addr = $urandom; dc_wdata = $urandom; dc_we = ~dc_we;
        end
      end
      if (ic_ready || dc_ready) begin
        rdy = n;
        got_d = dc_ready;
        chk({tag, "_ic_rdata"}, ic_rdata, exp_ic);
        chk({tag, "_dc_rdata"}, dc_rdata, exp_dc);
      end
    end
    if (rdy < 0) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no ready within 60 cycles, expected one", tag);
    end else begin
      chkb({tag, "_port_is_dc"}, got_d, exp_d);
      chk({tag, "_ready_cycle"}, rdy, l + 1);
      chk({tag, "_req_first"}, req_first, 1);
      chk({tag, "_req_cycles"}, req_cnt, l);
      chkb({tag, "_fields_held"}, bad_hold, 1'b0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic txn(input string tag, input logic i, input logic [31:0] ia, input logic d, input logic w,
                     input logic [31:0] da, input logic [31:0] wd, input int l, input logic exp_d,
                     input logic [31:0] exp_rd, input bit scr);
    logic [31:0] e_ic, e_dc;
    e_ic = exp_d ? cur_ic : exp_rd;
    e_dc = exp_d ? exp_rd : cur_dc;
    drive(i, ia, d, w, da, wd);
    run_txn(tag, l, exp_d, exp_d ? da : ia, exp_d && w, wd, e_ic, e_dc, scr);
    cur_ic = e_ic;
    cur_dc = e_dc;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic ic, dc, we;
    logic [31:0] ia, da, wd;
    int lat;
    logic exp_d;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [8];
  bit pat [6];
  logic [31:0] ref_mem [8];

  initial begin
    int streak, ia_k, da_k, l;
    logic ip, dp, we, exp_d;
    logic [31:0] wd, exp_rd;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,         1, 1'b0, 32'h2008_0005};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h100, 32'hDEAD_BEEF, 3, 1'b1, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h100, 32'h0,         3, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h0,   32'h0,         2, 1'b0, 32'hDEAD_BEEF};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h40,  32'h100, 32'h0,         1, 1'b1, 32'hDEAD_BEEF};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h40,  32'h0,   32'h0,         1, 1'b0, 32'h2008_0005};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h0,   32'h44,  32'h1234_5678, 2, 1'b1, 32'hDEAD_BEEF};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 32'h44,  32'h0,   32'h0,         5, 1'b0, 32'h1234_5678};
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    mem[32'h40] = 32'h2008_0005;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chkb("rst_mem_req", mem_req, 1'b0);
    chkb("rst_mem_we", mem_we, 1'b0);
    chkb("rst_ic_ready", ic_ready, 1'b0);
    chkb("rst_dc_ready", dc_ready, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
    chk("rst_ic_rdata", ic_rdata, 32'h0);
    chk("rst_dc_rdata", dc_rdata, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int k = 0; k < 8; k++)
      txn($sformatf("vec%0d", k), tbl[k].ic, tbl[k].ia, tbl[k].dc, tbl[k].we, tbl[k].da, tbl[k].wd,
          tbl[k].lat, tbl[k].exp_d, tbl[k].exp_rd, 1'b1);

    for (int k = 0; k < 6; k++)
      txn($sformatf("arb%0d", k), 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1 + k % 2, pat[k],
          pat[k] ? 32'hDEAD_BEEF : 32'h2008_0005, 1'b1);

    for (int k = 0; k < 3; k++)
      txn($sformatf("lone%0d", k), 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    txn("lone_both", 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);
    txn("lone_ic", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h2008_0005, 1'b1);

    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0);
    lat = 4;
    @(negedge clk);
    chkb("abort_idle_req", mem_req, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chkb("abort_busy1_req", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chkb("abort_busy2_req", mem_req, 1'b1);
    @(posedge clk); #1;
    reset = 1'b0;
    dc_req = 1'b0;
    @(negedge clk);
    chkb("abort_req_dropped", mem_req, 1'b0);
    chk("abort_mem_addr", mem_addr, 32'h0);
    chk("abort_dc_rdata", dc_rdata, 32'h0);
    chk("abort_ic_rdata", ic_rdata, 32'h0);
    chkb("abort_no_ready0", dc_ready, 1'b0);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chkb($sformatf("abort_no_ready%0d", k), dc_ready, 1'b0);
    end
    @(posedge clk); #1;
    cur_ic = '0;
    cur_dc = '0;
    txn("post_abort", 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, 2, 1'b0, 32'h2008_0005, 1'b1);
    txn("post_abort_ld", 1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 1'b1);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chkb($sformatf("spur%0d_ic_ready", k), ic_ready, 1'b0);
      chkb($sformatf("spur%0d_dc_ready", k), dc_ready, 1'b0);
      chkb($sformatf("spur%0d_mem_req", k), mem_req, 1'b0);
      @(posedge clk); #1;
      if (k == 2) spur = 1'b0;
    end
    chk("spur_ic_rdata", ic_rdata, cur_ic);
    chk("spur_dc_rdata", dc_rdata, cur_dc);
    txn("post_spur", 1'b1, 32'h44, 1'b0, 1'b0, 32'h0, 32'h0, 1, 1'b0, 32'h1234_5678, 1'b1);

    do_reset();
    cur_ic = '0;
    cur_dc = '0;
    streak = 0;
    for (int k = 0; k < 8; k++) begin
      ref_mem[k] = $urandom;
      mem[32'h1000 + 32'(4 * k)] = ref_mem[k];
    end
    ip = 1'b1; dp = 1'b1;
    ia_k = $urandom_range(0, 7); da_k = $urandom_range(0, 7);
    we = 1'($urandom_range(0, 1)); wd = $urandom;
    for (int t = 0; t < 60; t++) begin
      l = $urandom_range(1, 4);
      exp_d = dp && !(ip && streak == MAXS);
      exp_rd = exp_d ? (we ? cur_dc : ref_mem[da_k]) : ref_mem[ia_k];
      txn($sformatf("rnd%0d", t), ip, 32'h1000 + 32'(4 * ia_k), dp, we, 32'h1000 + 32'(4 * da_k), wd,
          l, exp_d, exp_rd, 1'b0);
      if (exp_d && we) ref_mem[da_k] = wd;
      streak = (exp_d && ip) ? (streak + 1 > MAXS ? MAXS : streak + 1) : 0;
      if (exp_d) begin
        dp = 1'($urandom_range(0, 1));
        da_k = $urandom_range(0, 7); we = 1'($urandom_range(0, 1)); wd = $urandom;
        if (!ip && !dp) dp = 1'b1;
      end else begin
        ip = 1'($urandom_range(0, 1));
        ia_k = $urandom_range(0, 7);
        if (!ip && !dp) ip = 1'b1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one unified memory between the pipeline's instruction-fetch port and its data-access port. It serialises requests from both ports, drives a single request/acknowledge memory interface, and returns read data with a one-cycle ready pulse that the pipeline uses as its stall release. Data accesses have priority, and a bounded streak counter keeps instruction fetch from starving.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_DC_STREAK, 2, maximum consecutive data grants while a fetch is pending (legal range 1..15)

Ports:
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high reset
- ic_req  in  1  instruction fetch request; held until ic_ready
- ic_addr  in  ADDR_W  fetch address; stable while ic_req is high
- ic_rdata  out  DATA_W  fetched word; valid when ic_ready is high
- ic_ready  out  1  one-cycle completion pulse for fetch
- dc_req  in  1  data request; held until dc_ready
- dc_we  in  1  1 = store, 0 = load
- dc_addr  in  ADDR_W  data address
- dc_wdata  in  DATA_W  store data
- dc_rdata  out  DATA_W  load data; valid when dc_ready is high
- dc_ready  out  1  one-cycle completion pulse for data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack
- mem_ack  in  1  memory completion; any latency of 1 cycle or more after mem_req rises

## Operation
- The FSM has five states: IDLE, BUSY_I, BUSY_D, RESP_I and RESP_D.
- IDLE: arbitration happens only in this state.
  - Both requests high and dc_streak < MAX_DC_STREAK -> grant data.
  - Both requests high and dc_streak == MAX_DC_STREAK -> grant fetch.
  - A single request -> grant it.
  - No request -> stay in IDLE.
- On grant, latch address, we and wdata into memory-side registers. The next state is BUSY_I or BUSY_D. A fetch always has mem_we = 0.
- BUSY_x: mem_req = 1 with the latched fields held constant. On mem_ack, capture mem_rdata into x_rdata and go to RESP_x.
- RESP_x: x_ready = 1 for exactly this one cycle, then go to IDLE. The requester deasserts req, or presents a new request, at this edge.
- For a store, dc_rdata is left unchanged (it keeps its previous value).
- dc_streak is a 4-bit counter:
  - increment on a data grant made while ic_req is high, saturating at MAX_DC_STREAK;
  - clear on any fetch grant;
  - clear on a data grant made while ic_req is low.
- mem_ack outside BUSY_x is ignored: no state change and no capture.
- Requester inputs that change while the port is BUSY have no effect; the latched values are used.
- Reset:
  - state = IDLE, dc_streak = 0;
  - mem_req, mem_we, ic_ready, dc_ready = 0;
  - mem_addr, mem_wdata, ic_rdata, dc_rdata = 0.
- Reset during BUSY or RESP aborts the transaction:
  - no ready pulse is produced;
  - mem_req drops in the cycle after reset is sampled;
  - the memory is reset by the same reset, so no ack is outstanding afterwards.

## Timing
- All outputs are registered.
- Minimum transaction, with req seen in IDLE at cycle 0:
  - cycle 1: BUSY, mem_req = 1;
  - mem_ack in cycle 1 gives x_ready in cycle 2;
  - IDLE in cycle 3.
- General case: ready rises 1 cycle after the mem_ack cycle.
- There is at least one IDLE cycle between consecutive transactions, so back-to-back throughput is one access per (ack latency + 2) cycles.
- ic_ready and dc_ready are never high in the same cycle.
- mem_req is never high in IDLE or RESP.

## Test plan
- Single fetch: ic_req = 1, ic_addr = 0x0000_0040, memory acks 1 cycle after mem_req with 0x2008_0005.
  - Required: mem_req, mem_we = 0, mem_addr = 0x40 in cycle 1.
  - Required: ic_ready = 1 and ic_rdata = 0x2008_0005 in cycle 2, for one cycle only.
- Store then load, ack latency 3:
  - Store dc_we = 1, addr 0x100, wdata 0xDEAD_BEEF -> mem_we = 1 with those values for 3 cycles; dc_ready pulses; dc_rdata unchanged.
  - Following load from 0x100 -> dc_rdata = 0xDEAD_BEEF.
- Simultaneous requests, MAX_DC_STREAK = 2, dc_req and ic_req both held continuously:
  - Required grant order: D, D, I, D, D, I.
  - dc_streak reads 0, 1, 2, 0 at the corresponding grants.
- Lone data requests (ic_req = 0 throughout) -> dc_streak stays 0; a later simultaneous request is granted to data.
- Reset asserted in the second cycle of BUSY_D (ack latency 4):
  - mem_req = 0 and state IDLE on the next cycle;
  - no dc_ready pulse;
  - a new ic_req afterwards completes normally.
- Spurious mem_ack in IDLE with mem_rdata = 0xFFFF_FFFF -> no ready pulse; ic_rdata and dc_rdata unchanged; no state change.
